// File: rtl/wb_io_pkg.sv
// Shared constants, response type and byte-lane merge helper for the
// Wishbone I/O register block.
package wb_io_pkg;

  localparam int DEF_DW        = 16;
  localparam int DEF_NREGS     = 4;
  localparam int DEF_LATENCY   = 2;
  localparam int DEF_MAX_OUTST = 2;

  // Widest data bus the merge helper handles; callers cast down to DW.
  localparam int MAX_DW = 64;

  // Response word carried through the ack delay line.
  localparam int RSP_DW = DEF_DW;
  typedef struct packed {
    logic              valid;
    logic [RSP_DW-1:0] data;
  } rsp_t;

  // Replace the bytes of old_v selected by sel with the same bytes of new_v.
  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0]   old_v,
    input logic [MAX_DW-1:0]   new_v,
    input logic [MAX_DW/8-1:0] sel
  );
    logic [MAX_DW-1:0] r;
    r = old_v;
    for (int b = 0; b < MAX_DW/8; b++)
      if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/wb_io_regs_if.sv
// Wishbone classic-pipelined bus between the CPU master and the I/O registers.
interface wb_io_regs_if
  import wb_io_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = $clog2(DEF_NREGS)
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   dat_m;
  logic [DW-1:0]   dat_s;
  logic            ack;
  logic            stall;

  modport master (output cyc, stb, we, adr, sel, dat_m, input dat_s, ack, stall);
  modport slave  (input cyc, stb, we, adr, sel, dat_m, output dat_s, ack, stall);
endinterface

// File: rtl/wb_io_pipe.sv
// Fixed-latency delay line for bus responses. A synchronous flush drops
// every valid bit in flight; data is left alone since it is only looked at
// alongside its valid.
module wb_io_pipe
  import wb_io_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int W       = $bits(rsp_t) - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);

  logic [LATENCY:1]         vld_pipe;
  logic [LATENCY:1][W-1:0]  dat_pipe;

  // Valid shift register, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      for (int s = 2; s <= LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  // Data shift register, runs alongside the valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_pipe <= '0;
    end else begin
      dat_pipe[1] <= in_dat;
      for (int s = 2; s <= LATENCY; s++) dat_pipe[s] <= dat_pipe[s-1];
    end
  end

  assign out_vld = vld_pipe[LATENCY];
  assign out_dat = dat_pipe[LATENCY];

endmodule

// File: rtl/wb_io_regs.sv
// Bank of byte-writable I/O registers on a pipelined Wishbone slave with a
// fixed ack latency and a cap on outstanding requests.
module wb_io_regs
  import wb_io_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int NREGS     = DEF_NREGS,
  parameter int AW        = (NREGS > 1) ? $clog2(NREGS) : 1,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int MAX_OUTST = DEF_MAX_OUTST
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_io_regs_if.slave        bus,
  output logic [NREGS*DW-1:0] regs_q,
  output logic [NREGS-1:0]   wr_pulse
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  logic [NREGS-1:0][DW-1:0] regs;
  logic [NREGS-1:0]         hit;
  logic [DW-1:0]            rd_dat;
  logic [DW-1:0]            rsp_dat;
  logic [DW-1:0]            pipe_dat;
  logic [DW-1:0]            dat_hold;
  logic                     pipe_vld;
  logic                     acc;
  logic [OW-1:0]            outst;

  assign acc = bus.cyc & bus.stb & ~bus.stall;

  // Address decode; an out-of-range address hits nothing and reads as 0.
  always_comb begin
    hit    = '0;
    rd_dat = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.adr == AW'(i)) begin
        hit[i] = 1'b1;
        rd_dat = regs[i];
      end
    end
  end

  // Register bank: byte-lane merge on an accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (acc && bus.we && hit[i])
          regs[i] <= DW'(lane_merge(MAX_DW'(regs[i]), MAX_DW'(bus.dat_m),
                                    (MAX_DW/8)'(bus.sel)));
    end
  end

  // One-cycle write strobe, raised even when no byte lane is selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_pulse <= '0;
    else        wr_pulse <= (acc && bus.we) ? hit : '0;
  end

  assign regs_q  = regs;
  assign rsp_dat = bus.we ? '0 : rd_dat;

  // Read data is captured at accept and emerges LATENCY cycles later.
  wb_io_pipe #(.LATENCY(LATENCY), .W(DW)) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (~bus.cyc),
    .in_vld  (acc),
    .in_dat  (rsp_dat),
    .out_vld (pipe_vld),
    .out_dat (pipe_dat)
  );

  // No ack outside a bus cycle: an aborted cycle loses its responses.
  assign bus.ack   = pipe_vld & bus.cyc;
  assign bus.dat_s = bus.ack ? pipe_dat : dat_hold;
  assign bus.stall = (outst == OW'(MAX_OUTST)) & ~bus.ack;

  // Keep the last returned word on dat_s between acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dat_hold <= '0;
    else if (bus.ack) dat_hold <= pipe_dat;
  end

  // Outstanding-request count; dropping cyc forgets everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else if (!bus.cyc) begin
      outst <= '0;
    end else begin
      case ({acc, bus.ack})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: outst <= outst;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_io_regs.sv
// Directed bench for wb_io_regs using three parameter sets:
//   a: NREGS=4 LATENCY=2 MAX_OUTST=2
//   b: NREGS=4 LATENCY=3 MAX_OUTST=1
//   c: NREGS=3 LATENCY=2 MAX_OUTST=2
module tb_wb_io_regs;

  logic clk;
  logic rst_n;

  wb_io_regs_if #(.DW(16), .AW(2)) ia ();
  wb_io_regs_if #(.DW(16), .AW(2)) ib ();
  wb_io_regs_if #(.DW(16), .AW(2)) ic ();

  logic [63:0] rq_a, rq_b;
  logic [47:0] rq_c;
  logic [3:0]  wp_a, wp_b;
  logic [2:0]  wp_c;

  wb_io_regs #(.DW(16), .NREGS(4), .LATENCY(2), .MAX_OUTST(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave), .regs_q(rq_a), .wr_pulse(wp_a));
  wb_io_regs #(.DW(16), .NREGS(4), .LATENCY(3), .MAX_OUTST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave), .regs_q(rq_b), .wr_pulse(wp_b));
  wb_io_regs #(.DW(16), .NREGS(3), .LATENCY(2), .MAX_OUTST(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ic.slave), .regs_q(rq_c), .wr_pulse(wp_c));

  int total = 0;
  int bad   = 0;

  logic        b_we  [6];
  logic [1:0]  b_adr [6];
  logic [15:0] b_dat [6];
  logic [15:0] b_exp [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ia.cyc = 0; ia.stb = 0; ia.we = 0; ia.adr = 0; ia.sel = 0; ia.dat_m = 0;
    ib.cyc = 0; ib.stb = 0; ib.we = 0; ib.adr = 0; ib.sel = 0; ib.dat_m = 0;
    ic.cyc = 0; ic.stb = 0; ic.we = 0; ic.adr = 0; ic.sel = 0; ic.dat_m = 0;
    b_we[0] = 1; b_adr[0] = 0; b_dat[0] = 16'hA0A0;
    b_we[1] = 1; b_adr[1] = 1; b_dat[1] = 16'hB1B1;
    b_we[2] = 1; b_adr[2] = 2; b_dat[2] = 16'hC2C2;
    b_we[3] = 0; b_adr[3] = 0; b_dat[3] = 16'h0000;
    b_we[4] = 0; b_adr[4] = 1; b_dat[4] = 16'h0000;
    b_we[5] = 0; b_adr[5] = 2; b_dat[5] = 16'h0000;
    b_exp[0] = 16'hA0A0; b_exp[1] = 16'hB1B1; b_exp[2] = 16'hC2C2;

    // ---- reset state
    tick; tick;
    chk("rst_ack",   ia.ack,   0);
    chk("rst_dat",   ia.dat_s, 0);
    chk("rst_stall", ia.stall, 0);
    chk("rst_regs",  rq_a,     0);
    chk("rst_wp",    wp_a,     0);
    chk("rst_regs_b", rq_b,    0);
    rst_n = 1'b1;
    tick;

    // ---- back-to-back write then read of reg 0
    ia.cyc = 1; ia.stb = 1; ia.we = 1; ia.adr = 0; ia.sel = 2'b11; ia.dat_m = 16'h5A5A;
    #1 chk("raw_stall_t0", ia.stall, 0);
    tick;
    chk("raw_stall_t1", ia.stall, 0);
    chk("raw_regs",     rq_a,     64'h0000_0000_0000_5A5A);
    chk("raw_wp",       wp_a,     4'b0001);
    chk("raw_ack_t1",   ia.ack,   0);
    ia.we = 0;
    tick;
    chk("raw_ack_t2",   ia.ack,   1);
    chk("raw_stall_t2", ia.stall, 0);
    chk("raw_wp_t2",    wp_a,     0);
    ia.stb = 0;
    tick;
    chk("raw_ack_t3",   ia.ack,   1);
    chk("raw_dat_t3",   ia.dat_s, 16'h5A5A);
    chk("raw_stall_t3", ia.stall, 0);
    tick;
    chk("raw_ack_t4",   ia.ack,   0);
    chk("raw_hold_t4",  ia.dat_s, 16'h5A5A);

    // ---- byte-lane writes to reg 2
    ia.stb = 1; ia.we = 1; ia.adr = 2; ia.sel = 2'b11; ia.dat_m = 16'h1234;
    tick;
    chk("lane_wp1",   wp_a, 4'b0100);
    chk("lane_regs1", rq_a, 64'h0000_1234_0000_5A5A);
    ia.sel = 2'b10; ia.dat_m = 16'hAB00;
    tick;
    chk("lane_wp2",   wp_a,   4'b0100);
    chk("lane_regs2", rq_a,   64'h0000_AB34_0000_5A5A);
    chk("lane_ack1",  ia.ack, 1);
    ia.we = 0;
    tick;
    chk("lane_wp3",   wp_a,   0);
    chk("lane_ack2",  ia.ack, 1);
    ia.stb = 0;
    tick;
    chk("lane_ack_rd", ia.ack,   1);
    chk("lane_dat_rd", ia.dat_s, 16'hAB34);
    tick;
    chk("lane_ack_end", ia.ack, 0);
    ia.cyc = 0;

    // ---- out-of-range address on a 3-register bank
    ic.cyc = 1; ic.stb = 1; ic.we = 1; ic.adr = 1; ic.sel = 2'b11; ic.dat_m = 16'h1111;
    tick;
    chk("oor_wp_r1", wp_c, 3'b010);
    ic.we = 0;
    tick;
    chk("oor_ack_w1", ic.ack, 1);
    ic.we = 1; ic.adr = 3; ic.dat_m = 16'hFFFF;
    tick;
    chk("oor_ack_r1", ic.ack,   1);
    chk("oor_dat_r1", ic.dat_s, 16'h1111);
    chk("oor_wp",     wp_c,     0);
    chk("oor_regs",   rq_c,     48'h0000_1111_0000);
    ic.we = 0;
    tick;
    chk("oor_ack_w3", ic.ack, 1);
    chk("oor_regs2",  rq_c,   48'h0000_1111_0000);
    ic.stb = 0;
    tick;
    chk("oor_ack_r3", ic.ack,   1);
    chk("oor_dat_r3", ic.dat_s, 0);
    tick;
    chk("oor_ack_end", ic.ack, 0);
    ic.cyc = 0;

    // ---- stall with LATENCY=3, MAX_OUTST=1, stb held high
    ib.cyc = 1;
    for (int k = 0; k < 6; k++) begin
      ib.stb = 1; ib.we = b_we[k]; ib.adr = b_adr[k]; ib.sel = 2'b11; ib.dat_m = b_dat[k];
      #1;
      chk($sformatf("stl_free_%0d", k), ib.stall, 0);
      if (k > 0) chk($sformatf("stl_ack_%0d", k), ib.ack, 1);
      if (k >= 4) chk($sformatf("stl_dat_%0d", k), ib.dat_s, b_exp[k-4]);
      tick;
      chk($sformatf("stl_hold1_%0d", k), ib.stall, 1);
      chk($sformatf("stl_nack1_%0d", k), ib.ack,   0);
      tick;
      chk($sformatf("stl_hold2_%0d", k), ib.stall, 1);
      chk($sformatf("stl_nack2_%0d", k), ib.ack,   0);
      tick;
    end
    chk("stl_ack_last", ib.ack,   1);
    chk("stl_dat_last", ib.dat_s, 16'hC2C2);
    chk("stl_regs",     rq_b,     64'h0000_C2C2_B1B1_A0A0);
    ib.stb = 0;
    tick;
    chk("stl_ack_end", ib.ack, 0);
    ib.cyc = 0;

    // ---- abort: two reads accepted, then cyc drops
    ia.cyc = 1; ia.stb = 1; ia.we = 0; ia.adr = 2;
    tick;
    ia.adr = 3;
    tick;
    ia.cyc = 0; ia.stb = 0;
    #1;
    chk("abt_ack_c2",  ia.ack,   0);
    chk("abt_hold_c2", ia.dat_s, 16'hAB34);
    tick;
    chk("abt_ack_c3",   ia.ack,   0);
    chk("abt_stall_c3", ia.stall, 0);
    tick;
    chk("abt_ack_c4", ia.ack, 0);
    ia.cyc = 1; ia.stb = 1; ia.we = 0; ia.adr = 0;
    #1 chk("abt_stall_new", ia.stall, 0);
    tick;
    chk("abt_ack_c5", ia.ack, 0);
    ia.stb = 0;
    tick;
    chk("abt_ack_new", ia.ack,   1);
    chk("abt_dat_new", ia.dat_s, 16'h5A5A);
    tick;
    chk("abt_ack_c7", ia.ack, 0);

    // ---- reset asserted with two reads in flight
    ia.stb = 1; ia.we = 1; ia.adr = 1; ia.sel = 2'b11; ia.dat_m = 16'hBEEF;
    tick;
    chk("rmb_regs", rq_a, 64'h0000_AB34_BEEF_5A5A);
    ia.we = 0;
    tick;
    chk("rmb_ack_w", ia.ack, 1);
    tick;
    ia.stb = 0;
    rst_n = 1'b0;
    #1;
    chk("rmb_ack",   ia.ack,   0);
    chk("rmb_regs0", rq_a,     0);
    chk("rmb_stall", ia.stall, 0);
    chk("rmb_dat",   ia.dat_s, 0);
    tick;
    chk("rmb_ack_r", ia.ack, 0);
    rst_n = 1'b1;
    tick;
    chk("rmb_ack_p1", ia.ack, 0);
    tick;
    chk("rmb_ack_p2",   ia.ack,   0);
    chk("rmb_stall_p2", ia.stall, 0);
    ia.cyc = 0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
